ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction-fetch stage directly upstream of the 1024x32 instruction ROM.
- Holds the PC and drives the ROM word address.
- Captures the ROM's combinational data word into an instruction register (IR) with a valid bit for the decode stage.
- Handles stall, jump/branch redirect, pipeline flush and halt detection.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_PC, 32'h0000_0800, PC loaded on flush (exception/restart entry).
- HALT_WORD, 32'h0000_000C, instruction encoding that halts fetch (syscall).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  decode cannot accept; hold PC and IR.
- flush  in  1  squash IR, redirect PC to FLUSH_PC.
- jump  in  1  unconditional redirect request.
- jump_target  in  32  jump destination (byte address).
- branch_taken  in  1  taken-branch redirect request.
- branch_target  in  32  branch destination (byte address).
- rom_dout  in  32  ROM data for rom_addr (combinational, same cycle).
- rom_addr  out  10  ROM word address = pc[11:2].
- pc  out  32  current fetch PC.
- ir  out  32  registered instruction.
- ir_pc  out  32  PC of the instruction in ir.
- ir_valid  out  1  ir holds a live instruction.
- halted  out  1  fetch stopped after HALT_WORD.
- fetch_cnt  out  32  number of instructions loaded into IR with ir_valid=1.

Behaviour:
- Reset (async, rst_n=0) sets outputs immediately:
  - pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, halted=0, fetch_cnt=0.
  - State = RUN.
- Fetch latency: rom_addr is combinational from pc. The ROM word appears in ir one edge later.
- States: RUN, HALTED.
- RUN: at each rising edge, evaluate in priority order; the first match applies.
  1. flush=1: pc<=FLUSH_PC, ir_valid<=0, ir unchanged. Flush overrides stall and halt detection.
  2. Halt detected (ir_valid=1, ir==HALT_WORD, stall=0):
     - go to HALTED, halted<=1, ir_valid<=0, pc held.
     - Any jump/branch in the same cycle is ignored.
  3. jump=1: pc<={jump_target[31:2],2'b00}, ir_valid<=0 (squashes the wrong-path word fetched this cycle). Overrides stall.
  4. branch_taken=1: same as jump using branch_target. jump wins if both are asserted.
  5. stall=1: pc, ir, ir_pc, ir_valid all held.
  6. Otherwise:
     - ir<=rom_dout, ir_pc<=pc, ir_valid<=1, pc<=pc+4, fetch_cnt<=fetch_cnt+1.
- HALTED:
  - pc, ir, ir_pc, fetch_cnt frozen; ir_valid=0.
  - stall, jump, branch_taken and flush are all ignored.
  - Exit only via reset.
- Width and wrap rules:
  - pc+4 wraps modulo 2^32.
  - rom_addr wraps modulo 1024 (pc 0x1000 maps to word 0).
  - fetch_cnt wraps modulo 2^32.
  - Redirect targets always have bits [1:0] forced to 0.
- Reset asserted mid-operation, including in HALTED: returns to RUN at RESET_PC. The first fetch occurs at the first edge after rst_n deasserts.
- No combinational path from stall/jump/branch/flush to rom_addr; redirects take effect on rom_addr the next cycle.

Test Plan:
- Reset, ROM words 0..3 = 0x11111111..0x44444444, no stall:
  - ir shows 0x11111111 (ir_pc=0), then 0x22222222 (ir_pc=4), etc.
  - rom_addr steps 0,1,2,3; fetch_cnt=4 after 4 edges.
- stall=1 for 3 cycles after the second fetch:
  - pc=8, ir=0x22222222 and ir_valid=1 held throughout.
  - Resume yields 0x33222...-free sequence 0x33333333 with no skipped or duplicated word.
- jump=1, jump_target=0x0000_0103 while stall=1:
  - next edge: pc=0x100, ir_valid=0.
  - the following edge: ir=ROM[64], ir_pc=0x100.
- jump=1 (target 0x200) and branch_taken=1 (target 0x300) in the same cycle: pc=0x200.
- ROM[2]=HALT_WORD: after ir=0x0000000C is consumed:
  - halted=1, ir_valid=0, pc frozen at 0xC.
  - a later jump=1 and flush=1 have no effect.
  - rst_n pulse restores pc=0, halted=0.
- flush=1 in the same cycle HALT_WORD is in ir: pc=FLUSH_PC=0x800, halted stays 0.
- Wrap: jump to 0x0FFC, then run two cycles: rom_addr=1023 then 0; pc=0x1000.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the 1024x32 instruction ROM,
// and registers the returned word into IR (with its PC and a valid bit) for
// decode. Handles stall, jump/branch redirect, flush and syscall halt.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] FLUSH_PC  = 32'h0000_0800,
  parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] rom_dout,
  output logic [9:0]  rom_addr,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  output logic        halted,
  output logic [31:0] fetch_cnt
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt, ir_nxt, ir_pc_nxt, fetch_cnt_nxt;
  logic        ir_valid_nxt;
  logic        halt_hit;

  // ROM word address comes only from the registered PC, so redirects reach
  // the ROM one cycle later and there is no control-to-address comb path.
  assign rom_addr = pc[11:2];
  assign halted   = (state == HALTED);

  // A syscall in IR halts fetch once decode has accepted it (no stall).
  assign halt_hit = ir_valid && (ir == HALT_WORD) && !stall;

  // Next-state and datapath selection; first matching condition wins.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    ir_nxt        = ir;
    ir_pc_nxt     = ir_pc;
    ir_valid_nxt  = ir_valid;
    fetch_cnt_nxt = fetch_cnt;
    case (state)
      RUN: begin
        if (flush) begin
          pc_nxt       = FLUSH_PC;
          ir_valid_nxt = 1'b0;
        end else if (halt_hit) begin
          state_nxt    = HALTED;
          ir_valid_nxt = 1'b0;
        end else if (jump) begin
          pc_nxt       = jump_target & 32'hFFFF_FFFC;
          ir_valid_nxt = 1'b0;
        end else if (branch_taken) begin
          pc_nxt       = branch_target & 32'hFFFF_FFFC;
          ir_valid_nxt = 1'b0;
        end else if (!stall) begin
          ir_nxt        = rom_dout;
          ir_pc_nxt     = pc;
          ir_valid_nxt  = 1'b1;
          pc_nxt        = pc + 32'd4;
          fetch_cnt_nxt = fetch_cnt + 32'd1;
        end
      end
      HALTED: begin
        ir_valid_nxt = 1'b0;
      end
      default: begin
        state_nxt    = RUN;
        ir_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and fetch registers; reset returns to RUN at RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pc        <= RESET_PC;
      ir        <= 32'd0;
      ir_pc     <= 32'd0;
      ir_valid  <= 1'b0;
      fetch_cnt <= 32'd0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      ir        <= ir_nxt;
      ir_pc     <= ir_pc_nxt;
      ir_valid  <= ir_valid_nxt;
      fetch_cnt <= fetch_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus randomized control traffic,
// compared cycle by cycle against a behavioural fetch model.
module tb_ifetch_unit;

  localparam logic [31:0] FLUSH_PC  = 32'h0000_0800;
  localparam logic [31:0] HALT_WORD = 32'h0000_000C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, jump = 1'b0, branch_taken = 1'b0;
  logic [31:0] jump_target = '0, branch_target = '0;
  logic [31:0] rom_dout;
  logic [9:0]  rom_addr;
  logic [31:0] pc, ir, ir_pc, fetch_cnt;
  logic        ir_valid, halted;

  logic [31:0] rom [0:1023];

  // behavioural model state
  logic [31:0] m_pc, m_ir, m_ir_pc, m_cnt;
  logic        m_vld, m_halt;

  int total = 0;
  int bad   = 0;

  ifetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .jump(jump),
    .jump_target(jump_target), .branch_taken(branch_taken),
    .branch_target(branch_target), .rom_dout(rom_dout), .rom_addr(rom_addr),
    .pc(pc), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted),
    .fetch_cnt(fetch_cnt)
  );

  assign rom_dout = rom[rom_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("rom_addr", {22'd0, rom_addr}, {22'd0, m_pc[11:2]});
    chk("ir", ir, m_ir);
    chk("ir_pc", ir_pc, m_ir_pc);
    chk("ir_valid", {31'd0, ir_valid}, {31'd0, m_vld});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_ir = 32'd0; m_ir_pc = 32'd0;
    m_vld = 1'b0; m_halt = 1'b0; m_cnt = 32'd0;
  endtask

  // asynchronous reset pulse, checked while rst_n is low, released mid-cycle
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one clock edge: apply the fetch rules to the model, then compare
  task automatic step();
    logic [31:0] n_pc, n_ir, n_ir_pc, n_cnt;
    logic        n_vld, n_halt;
    n_pc = m_pc; n_ir = m_ir; n_ir_pc = m_ir_pc; n_cnt = m_cnt;
    n_vld = m_vld; n_halt = m_halt;
    if (m_halt) begin
      n_vld = 1'b0;
    end else if (flush) begin
      n_pc = FLUSH_PC; n_vld = 1'b0;
    end else if (m_vld && m_ir == HALT_WORD && !stall) begin
      n_halt = 1'b1; n_vld = 1'b0;
    end else if (jump) begin
      n_pc = {jump_target[31:2], 2'b00}; n_vld = 1'b0;
    end else if (branch_taken) begin
      n_pc = {branch_target[31:2], 2'b00}; n_vld = 1'b0;
    end else if (!stall) begin
      n_ir = rom[m_pc[11:2]]; n_ir_pc = m_pc; n_vld = 1'b1;
      n_pc = m_pc + 32'd4; n_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ir = n_ir; m_ir_pc = n_ir_pc; m_cnt = n_cnt;
    m_vld = n_vld; m_halt = n_halt;
    check_all();
  endtask

  task automatic idle();
    stall = 1'b0; flush = 1'b0; jump = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 | i;
    rom[0] = 32'h1111_1111; rom[1] = 32'h2222_2222;
    rom[2] = 32'h3333_3333; rom[3] = 32'h4444_4444;
    rom[64] = 32'h6464_6464;
    model_reset();

    // reset state while rst_n held low from time 0
    #3 check_all();
    chk("rst_pc", pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // straight-line fetch
    step();
    chk("f1_ir", ir, 32'h1111_1111);
    chk("f1_irpc", ir_pc, 32'd0);
    step();
    chk("f2_ir", ir, 32'h2222_2222);
    chk("f2_pc", pc, 32'd8);

    // stall three cycles after the second fetch
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ir", ir, 32'h2222_2222);
      chk("stall_pc", pc, 32'd8);
      chk("stall_vld", {31'd0, ir_valid}, 32'd1);
    end
    stall = 1'b0;
    step();
    chk("resume_ir", ir, 32'h3333_3333);
    step();
    chk("f4_ir", ir, 32'h4444_4444);
    chk("f4_cnt", fetch_cnt, 32'd4);

    // jump overrides stall, low target bits dropped
    stall = 1'b1; jump = 1'b1; jump_target = 32'h0000_0103;
    step();
    chk("jmp_pc", pc, 32'h100);
    chk("jmp_vld", {31'd0, ir_valid}, 32'd0);
    idle();
    step();
    chk("jmp_ir", ir, 32'h6464_6464);
    chk("jmp_irpc", ir_pc, 32'h100);

    // jump beats branch
    jump = 1'b1; jump_target = 32'h200;
    branch_taken = 1'b1; branch_target = 32'h300;
    step();
    chk("jmp_vs_br", pc, 32'h200);
    idle();

    // wrap of the ROM word address
    jump = 1'b1; jump_target = 32'h0FFC;
    step();
    chk("wrap_a1", {22'd0, rom_addr}, 32'd1023);
    idle();
    step();
    chk("wrap_a0", {22'd0, rom_addr}, 32'd0);
    chk("wrap_pc", pc, 32'h1000);
    step();

    // halt on syscall at word 2
    rom[2] = HALT_WORD;
    do_reset();
    step(); step(); step();
    chk("h_ir", ir, HALT_WORD);
    step();
    chk("h_halted", {31'd0, halted}, 32'd1);
    chk("h_vld", {31'd0, ir_valid}, 32'd0);
    chk("h_pc", pc, 32'hC);
    jump = 1'b1; jump_target = 32'h400; flush = 1'b1; stall = 1'b1;
    step(); step();
    chk("h_frozen", pc, 32'hC);
    idle();
    do_reset();
    chk("h_rst_halted", {31'd0, halted}, 32'd0);
    chk("h_rst_pc", pc, 32'd0);

    // flush wins over halt detection
    step(); step(); step();
    flush = 1'b1;
    step();
    chk("fl_pc", pc, FLUSH_PC);
    chk("fl_halted", {31'd0, halted}, 32'd0);
    idle();
    step();
    rom[2] = 32'h3333_3333;

    // randomized traffic
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 15) == 0) ? HALT_WORD : $urandom;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (m_halt && $urandom_range(0, 5) == 0) begin
        idle();
        do_reset();
      end
      stall         = ($urandom_range(0, 3) == 0);
      jump          = ($urandom_range(0, 11) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      flush         = ($urandom_range(0, 29) == 0);
      jump_target   = $urandom;
      branch_target = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_0FFF) : $urandom;
      step();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
